sysbus_mem_responder: RTL and testbench

Memory-side responder for the processor's multiplexed 16-bit SysBus. It latches an address on ALE, then serves read cycles (nME, nOE low) by driving word data back onto the bus, and write cycles (nME, nWE low) by committing bus data to an internal word array. It is the counterpart to the control unit's fetch, LDW and STW bus sequences, and sits between the SysBus pad logic and on-chip RAM.

---
 rtl/sysbus_mem_responder.sv | 138 +++++++++++++
 tb/tb_sysbus_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: memory-side responder for the multiplexed 16-bit SysBus.
// Ports: Clock/Reset (sync, active-high); ALE,nME,nOE,nWE,SysBusIn from pads;
// SysBusOut/SysBusOe read drive, Ready, Selected, BusErr (all registered).
module sysbus_mem_responder #(
  parameter int          AW      = 8,
  parameter logic [15:0] BASE    = 16'h0000,
  parameter int          RD_WAIT = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ALE,
  input  logic        nME,
  input  logic        nOE,
  input  logic        nWE,
  input  logic [15:0] SysBusIn,
  output logic [15:0] SysBusOut,
  output logic        SysBusOe,
  output logic        Ready,
  output logic        Selected,
  output logic        BusErr
);

  typedef enum logic [2:0] {
    IDLE, ADDR, RWAIT, READ, WRITE
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(RD_WAIT - 1);

  state_t        state_q, state_d;
  // Only the index bits of the latched address are kept; the region
  // decision is captured in sel_q at the same edge.
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   dout_q, dout_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic          sel_q, sel_d;
  logic          oe_q, oe_d;
  logic          err_q, err_d;
  logic          we;
  logic [15:0]   mem_q [2**AW];

  logic rd_req, wr_req, viol, hit;

  assign rd_req = !nME && !nOE && nWE;
  assign wr_req = !nME && !nWE && nOE;
  assign viol   = !nME && !nOE && !nWE && sel_q;
  assign hit    = (SysBusIn[15:AW] == BASE[15:AW]);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wcnt_d  = wcnt_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    we      = 1'b0;
    if (ALE) begin
      // New address phase aborts whatever was in flight.
      addr_d  = SysBusIn[AW-1:0];
      sel_d   = hit;
      state_d = ADDR;
    end else if (state_q != IDLE && viol) begin
      err_d   = 1'b1;
      state_d = ADDR;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (sel_q && rd_req) begin
            if (RD_WAIT == 0) begin
              state_d = READ;
            end else begin
              state_d = RWAIT;
              wcnt_d  = WAIT_INIT;
            end
          end else if (sel_q && wr_req) begin
            state_d = WRITE;
            wdata_d = SysBusIn;
          end
        end
        RWAIT: begin
          if (!rd_req)           state_d = ADDR;
          else if (wcnt_q == '0) state_d = READ;
          else                   wcnt_d = wcnt_q - 2'd1;
        end
        READ: begin
          if (!rd_req) state_d = ADDR;
        end
        WRITE: begin
          // Commit the last value sampled while the strobe was low.
          if (nWE || nME) begin
            we      = 1'b1;
            state_d = ADDR;
          end else begin
            wdata_d = SysBusIn;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    oe_d   = (state_d == READ);
    dout_d = oe_d ? mem_q[addr_q] : 16'h0000;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sel_q   <= 1'b0;
      wcnt_q  <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wcnt_q  <= wcnt_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Array is not cleared by reset.
  always_ff @(posedge Clock) begin
    if (we && !Reset) mem_q[addr_q] <= wdata_q;
  end

  assign SysBusOut = dout_q;
  assign SysBusOe  = oe_q;
  assign Ready     = oe_q;
  assign Selected  = sel_q;
  assign BusErr    = err_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: directed bench for sysbus_mem_responder.
// Three instances share the bus: RD_WAIT=0, RD_WAIT=2, and BASE=16'h0100.
module tb_sysbus_mem_responder;

  logic        clk, rst;
  logic        ale, nme, noe, nwe;
  logic [15:0] din;
  logic [15:0] o0, o1, o2;
  logic        oe0, oe1, oe2;
  logic        rdy0, rdy1, rdy2;
  logic        sel0, sel1, sel2;
  logic        err0, err1, err2;

  int n_chk = 0;
  int n_err = 0;

  sysbus_mem_responder #(.AW(8), .BASE(16'h0000), .RD_WAIT(0)) u0 (
    .Clock(clk), .Reset(rst), .ALE(ale), .nME(nme), .nOE(noe), .nWE(nwe),
    .SysBusIn(din), .SysBusOut(o0), .SysBusOe(oe0), .Ready(rdy0),
    .Selected(sel0), .BusErr(err0)
  );

  sysbus_mem_responder #(.AW(8), .BASE(16'h0100), .RD_WAIT(0)) u1 (
    .Clock(clk), .Reset(rst), .ALE(ale), .nME(nme), .nOE(noe), .nWE(nwe),
    .SysBusIn(din), .SysBusOut(o1), .SysBusOe(oe1), .Ready(rdy1),
    .Selected(sel1), .BusErr(err1)
  );

  sysbus_mem_responder #(.AW(8), .BASE(16'h0000), .RD_WAIT(2)) u2 (
    .Clock(clk), .Reset(rst), .ALE(ale), .nME(nme), .nOE(noe), .nWE(nwe),
    .SysBusIn(din), .SysBusOut(o2), .SysBusOe(oe2), .Ready(rdy2),
    .Selected(sel2), .BusErr(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic a, input logic me, input logic oe,
                     input logic we, input logic [15:0] d);
    ale = a; nme = me; noe = oe; nwe = we; din = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
  endtask

  task automatic addr(input logic [15:0] a);
    drv(1'b1, 1'b1, 1'b1, 1'b1, a);
    step();
  endtask

  task automatic rd();
    drv(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr(a);
    drv(1'b0, 1'b0, 1'b1, 1'b0, d);
    step();
    idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst_oe", oe0, 1'b0);
    chk("rst_rdy", rdy0, 1'b0);
    chk("rst_sel", sel0, 1'b0);
    chk("rst_err", err0, 1'b0);
    chk("rst_out", o0, 16'h0000);
    rst = 1'b0;

    // Read strobes in IDLE without an address phase are ignored.
    rd();
    step();
    step();
    chk("idle_oe", oe0, 1'b0);
    chk("idle_err", err0, 1'b0);
    idle();
    step();

    // Preload Mem[5] and check region decode on ALE.
    addr(16'h0005);
    chk("sel_hit", sel0, 1'b1);
    chk("sel_miss", sel1, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    step();
    idle();
    step();

    // Fetch-style read.
    addr(16'h0005);
    rd();
    step();
    chk("rd0_oe", oe0, 1'b1);
    chk("rd0_rdy", rdy0, 1'b1);
    chk("rd0_data", o0, 16'hBEEF);
    chk("rw2_rdy_c1", rdy2, 1'b0);
    step();
    chk("rd0_data_c2", o0, 16'hBEEF);
    chk("rw2_rdy_c2", rdy2, 1'b0);
    step();
    chk("rw2_rdy_c3", rdy2, 1'b1);
    chk("rw2_data", o2, 16'hBEEF);
    chk("miss_oe", oe1, 1'b0);
    idle();
    step();
    chk("rel_oe", oe0, 1'b0);
    chk("rel_rdy", rdy0, 1'b0);
    chk("rel_out", o0, 16'h0000);
    chk("rel_oe2", oe2, 1'b0);

    // STW-style write then immediate re-read.
    addr(16'h0012);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 16'h1111);
    step();
    drv(1'b0, 1'b0, 1'b1, 1'b0, 16'h2222);
    step();
    idle();
    step();
    rd();
    step();
    chk("raw_data", o0, 16'h2222);
    idle();
    step();

    // Withdraw during wait states: never drives.
    addr(16'h0003);
    rd();
    step();
    idle();
    step();
    chk("wd_rdy", rdy2, 1'b0);
    step();
    chk("wd_oe", oe2, 1'b0);
    step();
    chk("wd_oe2", oe2, 1'b0);

    // Region miss on the BASE=0x100 instance.
    wr(16'h0103, 16'hCAFE);
    addr(16'h0203);
    chk("miss_sel1", sel1, 1'b0);
    chk("miss_sel0", sel0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD);
    step();
    idle();
    step();
    rd();
    step();
    chk("miss_rd_oe", oe1, 1'b0);
    step();
    chk("miss_rd_rdy", rdy1, 1'b0);
    idle();
    step();
    addr(16'h0103);
    chk("hit_sel1", sel1, 1'b1);
    rd();
    step();
    chk("miss_mem", o1, 16'hCAFE);
    idle();
    step();

    // Violation: no write, one-cycle BusErr.
    wr(16'h0007, 16'hAAAA);
    addr(16'h0007);
    drv(1'b0, 1'b0, 1'b0, 1'b0, 16'h7777);
    step();
    chk("viol_err", err0, 1'b1);
    chk("viol_oe", oe0, 1'b0);
    chk("viol_err_miss", err1, 1'b0);
    idle();
    step();
    chk("viol_err_end", err0, 1'b0);
    rd();
    step();
    chk("viol_nowr", o0, 16'hAAAA);
    idle();
    step();

    // ALE during WRITE aborts the commit and latches the new address.
    wr(16'h0008, 16'h1234);
    wr(16'h0009, 16'h9999);
    addr(16'h0008);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 16'h5555);
    step();
    drv(1'b1, 1'b0, 1'b1, 1'b0, 16'h0009);
    step();
    idle();
    step();
    rd();
    step();
    chk("abort_newaddr", o0, 16'h9999);
    idle();
    step();
    addr(16'h0008);
    rd();
    step();
    chk("abort_nowr", o0, 16'h1234);
    idle();
    step();

    // Reset mid-read.
    addr(16'h0005);
    rd();
    step();
    chk("pre_rst_oe", oe0, 1'b1);
    rst = 1'b1;
    step();
    chk("mrst_oe", oe0, 1'b0);
    chk("mrst_rdy", rdy0, 1'b0);
    chk("mrst_sel", sel0, 1'b0);
    rst = 1'b0;
    step();
    chk("mrst_idle_oe", oe0, 1'b0);
    step();
    chk("mrst_idle_oe2", oe0, 1'b0);
    idle();
    step();
    addr(16'h0005);
    rd();
    step();
    chk("mem_kept", o0, 16'hBEEF);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
